mux_arbiter: RTL
================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive grant cycles while the other requester waits; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset; synchronous and active-high.
REQ-004 req_a  input  1  requester A wants the shared 1-bit channel.
REQ-005 req_b  input  1  requester B wants the shared 1-bit channel.
REQ-006 data_a  input  1  requester A data bit.
REQ-007 data_b  input  1  requester B data bit.
REQ-008 gnt_a  output  1  registered; A owns the channel this cycle.
REQ-009 gnt_b  output  1  registered; B owns the channel this cycle.
REQ-010 sel  output  1  registered mux select; 1 selects data_a, 0 selects data_b.
REQ-011 y  output  1  combinational mux output: sel ? data_a : data_b.
REQ-012 y_valid  output  1  combinational; equals gnt_a | gnt_b.

Function
REQ-013 FSM states: IDLE, OWN_A, OWN_B; gnt_a=1 only in OWN_A, gnt_b=1 only in OWN_B; gnt_a and gnt_b are never both 1.
REQ-014 sel=1 in OWN_A, 0 in OWN_B; in IDLE sel keeps its previous value.
REQ-015 Internal last-owner pointer: 1 = A was last granted, 0 = B; updated on every entry to OWN_A/OWN_B.
REQ-016 IDLE: only req_a -> OWN_A; only req_b -> OWN_B; both -> requester that is NOT the last owner; neither -> stay IDLE.
REQ-017 Grant latency: a request sampled at edge N while IDLE produces the grant in the cycle after edge N (one cycle).
REQ-018 hold_cnt: 4-bit counter; cleared on every state entry; increments each cycle in OWN_A/OWN_B; saturates at MAX_HOLD.
REQ-019 OWN_A: req_a=0 and req_b=1 -> OWN_B; req_a=0 and req_b=0 -> IDLE; req_a=1, req_b=1 and hold_cnt==MAX_HOLD-1 -> OWN_B; otherwise stay.
REQ-020 OWN_B: symmetric to REQ-019 with A and B swapped.
REQ-021 Owner with no competitor keeps the grant indefinitely; hold_cnt saturates, no forced release.
REQ-022 Handover is direct (OWN_A <-> OWN_B with no IDLE cycle); no cycle has y_valid=0 while any request is pending and the FSM is not in IDLE.
REQ-023 With both requesting continuously, grants alternate in exact blocks of MAX_HOLD cycles.
REQ-024 MAX_HOLD=1 with both requesting: grant alternates every cycle.
REQ-025 Request dropped and reasserted in the same cycle as a switch: evaluated on sampled values only; no glitch or double grant.

Reset
REQ-026 reset=1 at a rising edge: state=IDLE, gnt_a=0, gnt_b=0, sel=0, hold_cnt=0, last-owner=B (so A wins the first tie).
REQ-027 reset overrides all other inputs, including mid-grant; the first grant after reset deasserts follows REQ-017.
REQ-028 Outputs are undefined before the first reset edge; the bench applies reset for at least 2 cycles.

Verification
REQ-029 Reset, then req_a=1, req_b=0, data_a=1 -> next cycle gnt_a=1, sel=1, y=1, y_valid=1; held for 20 cycles with no release.
REQ-030 Reset, then req_a=req_b=1 held, MAX_HOLD=4 -> gnt_a for 4 cycles, gnt_b for 4, gnt_a for 4; never both high, y_valid stays 1.
REQ-031 OWN_B with req_b dropped and req_a=1 -> next cycle gnt_a=1, gnt_b=0, sel=1, y follows data_a toggling 0/1.
REQ-032 Both requests dropped while in OWN_A -> next cycle IDLE, y_valid=0, sel stays 1; then both requests asserted together -> B granted (last owner A).
REQ-033 reset asserted at hold_cnt=2 in OWN_B -> next cycle gnt_a=gnt_b=0, sel=0; reset released with req_a=req_b=1 -> A granted first.
REQ-034 MAX_HOLD=1, both requests held -> gnt_a/gnt_b alternate every cycle for 10 cycles; y equals data of the granted requester each cycle.

Source files
------------

// File: rtl/mux_arbiter.sv
// Two-requester arbiter for a shared 1-bit channel with round-robin tie-break
// and a bounded hold time while the other requester waits.
module mux_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic req_a,
   input  logic req_b,
   input  logic data_a,
   input  logic data_b,
   output logic gnt_a,
   output logic gnt_b,
   output logic sel,
   output logic y,
   output logic y_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   localparam logic [3:0] HOLD_MAX  = 4'(MAX_HOLD);
   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   state_t     state_reg, state_next;
   logic [3:0] hold_cnt_reg, hold_cnt_next;
   logic       last_a_reg, last_a_next;
   logic       sel_reg, sel_next;
   logic       gnt_a_reg, gnt_b_reg;
   logic       hold_expired;

   // ">=" rather than "==" so a competitor arriving after the counter has
   // saturated still gets the channel instead of waiting forever.
   assign hold_expired = (hold_cnt_reg >= HOLD_LAST);

   always_comb begin
      state_next    = state_reg;
      hold_cnt_next = hold_cnt_reg;
      last_a_next   = last_a_reg;
      sel_next      = sel_reg;

      case (state_reg)
         IDLE: begin
            if (req_a && req_b)
               state_next = last_a_reg ? OWN_B : OWN_A;
            else if (req_a)
               state_next = OWN_A;
            else if (req_b)
               state_next = OWN_B;
         end
         OWN_A: begin
            if (!req_a)
               state_next = req_b ? OWN_B : IDLE;
            else if (req_b && hold_expired)
               state_next = OWN_B;
         end
         OWN_B: begin
            if (!req_b)
               state_next = req_a ? OWN_A : IDLE;
            else if (req_a && hold_expired)
               state_next = OWN_A;
         end
         default: state_next = IDLE;
      endcase

      if (state_next != state_reg)
         hold_cnt_next = 4'd0;
      else if (state_reg != IDLE && hold_cnt_reg < HOLD_MAX)
         hold_cnt_next = hold_cnt_reg + 4'd1;

      if (state_next == OWN_A) begin
         sel_next = 1'b1;
         if (state_reg != OWN_A)
            last_a_next = 1'b1;
      end else if (state_next == OWN_B) begin
         sel_next = 1'b0;
         if (state_reg != OWN_B)
            last_a_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         hold_cnt_reg <= 4'd0;
         last_a_reg   <= 1'b0;
         sel_reg      <= 1'b0;
         gnt_a_reg    <= 1'b0;
         gnt_b_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         hold_cnt_reg <= hold_cnt_next;
         last_a_reg   <= last_a_next;
         sel_reg      <= sel_next;
         gnt_a_reg    <= (state_next == OWN_A);
         gnt_b_reg    <= (state_next == OWN_B);
      end
   end

   assign gnt_a   = gnt_a_reg;
   assign gnt_b   = gnt_b_reg;
   assign sel     = sel_reg;
   assign y       = sel_reg ? data_a : data_b;
   assign y_valid = gnt_a_reg | gnt_b_reg;

endmodule
